apb_master_ctrl: RTL
====================

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, max ACCESS wait cycles before abort (range 1..255; used only with APB_TIMEOUT_EN).
REQ-002 SHALL have ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  synchronous active-low reset.
- req_valid  in  1  local transfer request.
- req_ready  out  1  high when a request can be accepted.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  9  [8] selects slave (0 = slave1, 1 = slave2); [7:0] is PADDR.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; valid with rsp_valid.
- rsp_err  out  1  timeout abort flag; valid with rsp_valid.
- PSEL1, PSEL2  out  1 each  APB slave selects.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  8  APB address.
- PWDATA  out  8  APB write data.
- PRDATA1, PRDATA2  in  8 each  slave read data.
- PREADY  in  1  shared slave ready; combinational from slave.
REQ-003 SHALL use one clock, PCLK; reset is synchronous and active-low on PRESETn.

Function
REQ-004 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE.
REQ-005 SHALL drive req_ready = 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready, and req_write, req_addr and req_wdata are registered at that edge.
REQ-006 SHALL transition IDLE -> SETUP on acceptance. In SETUP: selected PSELx = 1, PENABLE = 0, and PADDR/PWRITE/PWDATA driven from the captured request.
REQ-007 SHALL transition SETUP -> ACCESS unconditionally after one cycle. In ACCESS: PENABLE = 1, PSELx held.
REQ-008 SHALL remain in ACCESS while PREADY = 0 (wait states), holding PSELx, PENABLE, PADDR, PWRITE and PWDATA stable.
REQ-009 SHALL complete on the edge where state = ACCESS and PREADY = 1:
- next state IDLE;
- rsp_valid = 1 for exactly the following cycle;
- rsp_err = 0;
- rsp_rdata = PRDATA1 or PRDATA2 (per captured req_addr[8]) sampled at that edge for reads, 8'h00 for writes.
REQ-010 SHALL deassert PSELx and PENABLE in IDLE; PADDR, PWRITE and PWDATA hold their last values in IDLE.
REQ-011 SHALL never assert PSEL1 and PSEL2 together.
REQ-012 SHALL accept a new request in the same cycle rsp_valid is high (back-to-back), giving a minimum of 3 cycles per transfer with a zero-wait slave.
REQ-013 SHALL ignore PREADY and PRDATAx outside ACCESS.
REQ-014 SHALL drive rsp_valid = 0 in every cycle other than a completion cycle; rsp_rdata and rsp_err hold their values between completions.

Reset
REQ-015 SHALL, on any edge with PRESETn = 0 (including mid-transfer), enter IDLE and clear to 0: PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the timeout counter.
REQ-016 SHALL drop any in-flight transfer on reset with no rsp_valid; req_ready = 1 in the first cycle after PRESETn returns high.

Configuration
REQ-017 SHALL, when macro APB_TIMEOUT_EN is defined:
- count consecutive ACCESS cycles with PREADY = 0 using an 8-bit counter, cleared on entry to SETUP;
- when the count reaches TIMEOUT_CYCLES, abort: next state IDLE, rsp_valid = 1, rsp_err = 1, rsp_rdata = 8'h00.
REQ-018 SHALL, when APB_TIMEOUT_EN is undefined, contain no counter, tie rsp_err to 0, and wait in ACCESS indefinitely.

Verification
REQ-019 Write: req addr 9'h005, wdata 8'hA5, PREADY=1 in ACCESS -> PSEL1=1 for 2 cycles, PENABLE=1 in 2nd cycle only, PADDR=8'h05, PWDATA=8'hA5, rsp_valid pulse 3rd cycle, rsp_err=0.
REQ-020 Read: req addr 9'h10A, PRDATA2=8'h3C -> only PSEL2 asserted, rsp_rdata=8'h3C with rsp_valid.
REQ-021 Wait states: PREADY held 0 for 3 ACCESS cycles then 1 -> ACCESS lasts 4 cycles, PADDR/PWDATA stable throughout, single rsp_valid.
REQ-022 Back-to-back: req_valid held high for two requests -> second SETUP starts the cycle after the first rsp_valid; 6 cycles total.
REQ-023 Reset mid-ACCESS: PRESETn=0 for one edge while PREADY=0 -> next cycle all outputs 0, no rsp_valid, req_ready=1.
REQ-024 With APB_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=8'h00; without the macro, still in ACCESS after 100 cycles.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// APB master controller: turns single local requests into APB transfers on
// one of two slaves (req_addr[8] picks the slave) and returns one response
// pulse per transfer.
// Optional build macro APB_TIMEOUT_EN: when it is defined, an ACCESS phase that
// waits TIMEOUT_CYCLES cycles without PREADY is aborted with rsp_err = 1.
// When it is not defined, the controller waits for PREADY indefinitely.
//
// state  | meaning
// IDLE   | no transfer; req_ready high, selects and enable low
// SETUP  | APB setup phase; PSELx high, PENABLE low
// ACCESS | APB access phase; PENABLE high, waits for PREADY

module apb_master_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [8:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       PSEL1,
    output logic       PSEL2,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA1,
    input  logic [7:0] PRDATA2,
    input  logic       PREADY
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0] state;
    logic       sel2;
    logic       accept;
    logic       done;
    logic       abort;
    logic [7:0] rdata_mux;

    assign accept    = req_valid && (state == IDLE);
    assign done      = (state == ACCESS) && PREADY;
    assign rdata_mux = sel2 ? PRDATA2 : PRDATA1;

    // Selects and enable decode straight from the state, so only one slave can
    // ever be selected and everything drops as soon as the FSM is back in IDLE.
    assign req_ready = (state == IDLE);
    assign PSEL1     = (state != IDLE) && !sel2;
    assign PSEL2     = (state != IDLE) && sel2;
    assign PENABLE   = (state == ACCESS);

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] to_cnt;
    logic       err_q;

    // A stalled cycle is aborted when it would bring the count up to the limit.
    assign abort   = (state == ACCESS) && !PREADY && ((to_cnt + 8'd1) == TO_LIMIT);
    assign rsp_err = err_q;

    // Counts consecutive stalled ACCESS cycles; restarts with every accepted request
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            to_cnt <= 8'h00;
        end else if (accept) begin
            to_cnt <= 8'h00;
        end else if ((state == ACCESS) && !PREADY) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    // Error flag: set by an abort, cleared by a normal completion, held otherwise
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            err_q <= 1'b0;
        end else if (done) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end
`else
    assign abort   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Main FSM: IDLE -> SETUP -> ACCESS -> IDLE
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= SETUP;
                SETUP:   state <= ACCESS;
                ACCESS:  if (done || abort) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the request on acceptance; the APB address, data and direction
    // then hold those values until the next request is accepted
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            sel2   <= 1'b0;
            PWRITE <= 1'b0;
            PADDR  <= 8'h00;
            PWDATA <= 8'h00;
        end else if (accept) begin
            sel2   <= req_addr[8];
            PWRITE <= req_write;
            PADDR  <= req_addr[7:0];
            PWDATA <= req_wdata;
        end
    end

    // One-cycle response pulse; the read data is held between completions
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            rsp_valid <= done || abort;
            if (done) begin
                rsp_rdata <= PWRITE ? 8'h00 : rdata_mux;
            end else if (abort) begin
                rsp_rdata <= 8'h00;
            end
        end
    end

endmodule
